// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone RAM round-robin arbiter.
// Also defines slice helpers for the flat per-master buses.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int unsigned MASTER_IDX_W = 2;
  localparam int unsigned RAM_LAT      = 1;

endpackage

`define WB_SLICE32(bus, i) bus[32*(i) +: 32]
`define WB_SLICE4(bus, i)  bus[4*(i) +: 4]

// File: rtl/wb_ram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first requester found searching upward from last+1, with wrap.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]  req,
  input  logic [MASTER_IDX_W-1:0] last,
  output logic [MASTER_IDX_W-1:0] idx,
  output logic                    any
);

  always_comb begin
    int unsigned j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      j = (32'(last) + k) % NUM_MASTERS;
      if (!any && req[MASTER_IDX_W'(j)]) begin
        idx = MASTER_IDX_W'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ram_rr_arbiter.sv
// Round-robin pipelined-Wishbone arbiter in front of the single-ported RAM.
// Bounded bursts give fairness; acks are routed back to the accepting master.
module wb_ram_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_cyc,
  input  logic [NUM_MASTERS-1:0]    m_stb,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [4*NUM_MASTERS-1:0]  m_sel,
  input  logic [32*NUM_MASTERS-1:0] m_adr,
  input  logic [32*NUM_MASTERS-1:0] m_dat_w,
  output logic [31:0]               m_dat_r,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [NUM_MASTERS-1:0]    m_stall,
  output logic [MASTER_IDX_W-1:0]   grant,
  output logic                      grant_valid,
  input  logic [31:0]               ram_in,
  output logic [31:0]               ram_out,
  output logic [31:0]               ram_adr,
  output logic [3:0]                ram_msk,
  output logic                      ram_enable,
  input  logic                      ram_busy
);

  localparam int unsigned BURST_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_num_masters
    $error("wb_ram_rr_arbiter: NUM_MASTERS must be 2..4");
  end
  if (RAM_LAT != 1) begin : g_bad_ram_lat
    $error("wb_ram_rr_arbiter: ack path assumes a single-cycle RAM");
  end

  arb_state_t                state, state_d;
  logic [MASTER_IDX_W-1:0]   grant_d, last_grant, last_grant_d;
  logic [MASTER_IDX_W-1:0]   ack_owner, pick_idx;
  logic [BURST_W-1:0]        burst_cnt, burst_d;
  logic                      ack_pend, pick_any;
  logic                      g_cyc, g_stb, g_we, other_req, preempt, accept;
  logic [NUM_MASTERS-1:0]    others;
  logic [31:0]               adr_a [NUM_MASTERS];
  logic [31:0]               dat_a [NUM_MASTERS];
  logic [3:0]                sel_a [NUM_MASTERS];

  // Unpack the flat buses so the owner mux is a plain array index.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign adr_a[i] = `WB_SLICE32(m_adr, i);
    assign dat_a[i] = `WB_SLICE32(m_dat_w, i);
    assign sel_a[i] = `WB_SLICE4(m_sel, i);
  end

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req  (m_cyc),
    .last (last_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign g_cyc     = m_cyc[grant];
  assign g_stb     = m_stb[grant];
  assign g_we      = m_we[grant];
  assign others    = m_cyc & ~(NUM_MASTERS'(1) << grant);
  assign other_req = |others;
  assign preempt   = (state == GRANT) && (MAX_BURST != 0) &&
                     (burst_cnt == BURST_W'(MAX_BURST)) && other_req;
  assign accept    = (state == GRANT) && g_cyc && g_stb && !ram_busy && !preempt;

  assign m_dat_r     = ram_in;
  assign ram_adr     = adr_a[grant];
  assign ram_out     = dat_a[grant];
  assign grant_valid = (state == GRANT) || (state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= MASTER_IDX_W'(NUM_MASTERS - 1);
      burst_cnt  <= '0;
      ack_pend   <= 1'b0;
      ack_owner  <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      burst_cnt  <= burst_d;
      ack_pend   <= accept;
      ack_owner  <= grant;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_grant_d = last_grant;
    burst_d      = burst_cnt;
    ram_enable   = 1'b0;
    ram_msk      = '0;
    m_stall      = m_cyc;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ram_enable     = g_stb && g_cyc;
        ram_msk        = g_we ? sel_a[grant] : 4'h0;
        m_stall[grant] = ram_busy || preempt;
        if (accept && burst_cnt != BURST_W'(MAX_BURST)) begin
          burst_d = burst_cnt + BURST_W'(1);
        end
        // Leaving with an ack in flight passes through DRAIN to deliver it.
        if (!g_cyc || preempt) begin
          state_d      = (ack_pend || accept) ? DRAIN : IDLE;
          last_grant_d = grant;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack follows the accept by one cycle; dropped cycles swallow it.
  always_comb begin
    m_ack = '0;
    if (ack_pend) m_ack[ack_owner] = m_cyc[ack_owner];
  end

endmodule

// File: tb/tb_wb_ram_rr_arbiter.sv
// Directed bench for wb_ram_rr_arbiter: cycle table plus hand sequences
// for burst preemption and asynchronous reset.
module tb_wb_ram_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned NV = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    m_cyc, m_stb, m_we;
  logic [15:0]   m_sel;
  logic [127:0]  m_adr, m_dat_w;
  logic [31:0]   m_dat_r, ram_in, ram_out, ram_adr;
  logic [3:0]    m_ack, m_stall, ram_msk;
  logic [1:0]    grant;
  logic          grant_valid, ram_enable, ram_busy;

  wb_ram_rr_arbiter #(.NUM_MASTERS(N), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r),
    .m_ack(m_ack), .m_stall(m_stall), .grant(grant), .grant_valid(grant_valid),
    .ram_in(ram_in), .ram_out(ram_out), .ram_adr(ram_adr), .ram_msk(ram_msk),
    .ram_enable(ram_enable), .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cyc, stb, we;
    logic       busy;
    logic [3:0] e_ack, e_stall;
    logic       e_en, e_gv;
    logic [1:0] e_grant;
    logic [3:0] e_msk;
    logic [1:0] e_m;
  } vec_t;

  vec_t tbl [NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_adr(input logic [1:0] m);
    return 32'h10 + 32'h1000 * 32'(m);
  endfunction

  function automatic logic [31:0] exp_dat(input logic [1:0] m);
    return 32'hA000_0000 + 32'(m);
  endfunction

  initial begin
    int acc, acks;
    logic chk_next, reached, st3_bad;

    //          rst  cyc     stb     we      bsy  ack     stall   en    gv    g     msk   m
    tbl[0]  = '{1'b1, 4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0101, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 4'h0, 2'd0};
    tbl[4]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 4'h0, 2'd0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 4'h0, 2'd0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0};
    tbl[7]  = '{1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0110, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0};
    tbl[8]  = '{1'b0, 4'b0110, 4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0110, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0};
    tbl[9]  = '{1'b0, 4'b0110, 4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd1, 4'hF, 2'd1};
    tbl[10] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd1, 4'h0, 2'd1};
    tbl[11] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd1, 4'h0, 2'd1};
    tbl[12] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd1, 4'h0, 2'd1};
    tbl[13] = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'h0, 2'd2};
    tbl[14] = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'h0, 2'd2};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'h0, 2'd2};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'h0, 2'd2};
    tbl[17] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd2, 4'h0, 2'd2};
    tbl[18] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 4'hF, 2'd0};
    tbl[19] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 4'hF, 2'd0};
    tbl[20] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 4'hF, 2'd0};
    tbl[21] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 4'hF, 2'd0};
    tbl[22] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 4'hF, 2'd0};
    tbl[23] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 4'h0, 2'd0};
    tbl[24] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'h0, 2'd0};

    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '1;
    ram_busy = 1'b0; ram_in = '0;
    for (int i = 0; i < 4; i++) begin
      m_adr[32*i +: 32]   = exp_adr(2'(i));
      m_dat_w[32*i +: 32] = exp_dat(2'(i));
    end
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; m_cyc = tbl[i].cyc; m_stb = tbl[i].stb;
      m_we = tbl[i].we; ram_busy = tbl[i].busy; ram_in = 32'hD00D_0000 + 32'(i);
      #2;
      chk($sformatf("r%0d ack", i),   32'(m_ack),       32'(tbl[i].e_ack));
      chk($sformatf("r%0d stall", i), 32'(m_stall),     32'(tbl[i].e_stall));
      chk($sformatf("r%0d en", i),    32'(ram_enable),  32'(tbl[i].e_en));
      chk($sformatf("r%0d gv", i),    32'(grant_valid), 32'(tbl[i].e_gv));
      chk($sformatf("r%0d grant", i), 32'(grant),       32'(tbl[i].e_grant));
      chk($sformatf("r%0d msk", i),   32'(ram_msk),     32'(tbl[i].e_msk));
      chk($sformatf("r%0d adr", i),   ram_adr,          exp_adr(tbl[i].e_m));
      chk($sformatf("r%0d wdat", i),  ram_out,          exp_dat(tbl[i].e_m));
      if (tbl[i].e_ack != 4'b0000)
        chk($sformatf("r%0d rdat", i), m_dat_r, 32'hD00D_0000 + 32'(i));
    end

    // Burst preemption: master 0 streams writes while master 3 waits.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_cyc = 4'b1001; m_stb = 4'b0001; m_we = 4'b0001; ram_busy = 1'b0;
    acc = 0; acks = 0; chk_next = 1'b0; reached = 1'b0; st3_bad = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      #2;
      if (grant_valid && grant == 2'd3) begin
        reached = 1'b1;
      end else begin
        if (chk_next) begin
          chk("preempt stall0", 32'(m_stall[0]), 32'd1);
          chk_next = 1'b0;
        end
        if (grant_valid && grant == 2'd0 && ram_enable && !m_stall[0]) begin
          acc++;
          if (acc == 4) chk_next = 1'b1;
        end
        if (m_ack[0]) acks++;
        if (grant_valid && grant == 2'd0 && !m_stall[3]) st3_bad = 1'b1;
        @(negedge clk);
      end
    end
    chk("preempt handover", 32'(reached), 32'd1);
    chk("preempt accepts",  32'(acc),     32'd4);
    chk("preempt acks",     32'(acks),    32'd4);
    chk("waiter stalled",   32'(st3_bad), 32'd0);

    // Asynchronous reset while master 3 holds the RAM with an ack in flight.
    m_cyc = 4'b1000; m_stb = 4'b1000; m_we = 4'b0000;
    @(negedge clk); #2;
    chk("pre-rst ack", 32'(m_ack),       32'b1000);
    chk("pre-rst en",  32'(ram_enable),  32'd1);
    chk("pre-rst gv",  32'(grant_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async rst en",    32'(ram_enable),  32'd0);
    chk("async rst ack",   32'(m_ack),       32'd0);
    chk("async rst gv",    32'(grant_valid), 32'd0);
    chk("async rst grant", 32'(grant),       32'd0);
    chk("async rst stall", 32'(m_stall),     32'b1000);
    @(negedge clk);
    rst = 1'b0; m_cyc = 4'b1001; m_stb = 4'b0000;
    #2;
    chk("post-rst idle gv", 32'(grant_valid), 32'd0);
    @(negedge clk); #2;
    chk("post-rst gv",    32'(grant_valid), 32'd1);
    chk("post-rst grant", 32'(grant),       32'd0);

    m_cyc = '0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
